// File: rtl/stream_fork_dyn.sv
// Valid/ready stream fork that copies each input beat to a per-beat selected subset of outputs.
// Elaboration-time choice between a zero-latency fork and a per-output registered (cut) stage.
module stream_fork_dyn #(
    parameter int unsigned N_OUP      = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CUT_OUTPUT = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [DATA_WIDTH-1:0]         data_i,
    input  logic [N_OUP-1:0]              sel_i,
    output logic [N_OUP-1:0]              valid_o,
    input  logic [N_OUP-1:0]              ready_i,
    output logic [N_OUP*DATA_WIDTH-1:0]   data_o
);

    if (CUT_OUTPUT == 0) begin : g_comb
        logic [N_OUP-1:0] done_q, done_d;
        logic             in_hs;

        // Outputs are held off while reset is asserted so a partial beat is abandoned cleanly.
        assign valid_o = {N_OUP{valid_i & rst_ni}} & sel_i & ~done_q;
        assign ready_o = valid_i & rst_ni & (&(~sel_i | done_q | ready_i));
        assign data_o  = {N_OUP{data_i}};
        assign in_hs   = valid_i & ready_o;

        always_comb begin
            done_d = done_q;
            if (in_hs) begin
                done_d = '0;
            end else begin
                done_d = done_q | (valid_o & ready_i);
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                done_q <= '0;
            end else begin
                done_q <= done_d;
            end
        end
    end else begin : g_cut
        logic [N_OUP-1:0]                 vq, vq_d;
        logic [N_OUP-1:0][DATA_WIDTH-1:0] dq, dq_d;
        logic [N_OUP-1:0]                 free;
        logic                             in_hs;

        assign free    = ~vq | ready_i;
        assign ready_o = rst_ni & (&(~sel_i | free));
        assign in_hs   = valid_i & ready_o;
        assign valid_o = vq;
        assign data_o  = dq;

        // Reload takes priority over drain so a same-cycle drain+reload stays valid.
        always_comb begin
            vq_d = vq;
            dq_d = dq;
            for (int i = 0; i < int'(N_OUP); i++) begin
                if (in_hs && sel_i[i]) begin
                    vq_d[i] = 1'b1;
                    dq_d[i] = data_i;
                end else if (vq[i] && ready_i[i]) begin
                    vq_d[i] = 1'b0;
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                vq <= '0;
                dq <= '0;
            end else begin
                vq <= vq_d;
                dq <= dq_d;
            end
        end
    end

endmodule

// File: tb/tb_stream_fork_dyn.sv
// Bench for stream_fork_dyn: a 3-output combinational instance and a 2-output cut instance.
module tb_stream_fork_dyn;

    localparam int unsigned DW = 8;
    localparam int unsigned NC = 3;
    localparam int unsigned NK = 2;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    // Combinational-mode instance
    logic             c_valid_i = 1'b0;
    logic             c_ready_o;
    logic [DW-1:0]    c_data_i = '0;
    logic [NC-1:0]    c_sel_i = '0;
    logic [NC-1:0]    c_valid_o;
    logic [NC-1:0]    c_ready_i = '0;
    logic [NC*DW-1:0] c_data_o;

    // Cut-mode instance
    logic             k_valid_i = 1'b0;
    logic             k_ready_o;
    logic [DW-1:0]    k_data_i = '0;
    logic [NK-1:0]    k_sel_i = '0;
    logic [NK-1:0]    k_valid_o;
    logic [NK-1:0]    k_ready_i = '0;
    logic [NK*DW-1:0] k_data_o;

    stream_fork_dyn #(.N_OUP(NC), .DATA_WIDTH(DW), .CUT_OUTPUT(0)) u_comb (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(c_valid_i), .ready_o(c_ready_o),
        .data_i(c_data_i), .sel_i(c_sel_i), .valid_o(c_valid_o), .ready_i(c_ready_i),
        .data_o(c_data_o)
    );

    stream_fork_dyn #(.N_OUP(NK), .DATA_WIDTH(DW), .CUT_OUTPUT(1)) u_cut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(k_valid_i), .ready_o(k_ready_o),
        .data_i(k_data_i), .sel_i(k_sel_i), .valid_o(k_valid_o), .ready_i(k_ready_i),
        .data_o(k_data_o)
    );

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] qc [NC][$];
    logic [DW-1:0] qk [NK][$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every output handshake pops the next expected payload for that output.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            for (int i = 0; i < int'(NC); i++) begin
                if (c_valid_o[i] && c_ready_i[i]) begin
                    if (qc[i].size() == 0) chk($sformatf("comb_unexpected_out%0d", i), 32'(c_data_o[i*DW +: DW]), 32'hFFFF_FFFF);
                    else chk($sformatf("comb_data_out%0d", i), 32'(c_data_o[i*DW +: DW]), 32'(qc[i].pop_front()));
                end
            end
            for (int i = 0; i < int'(NK); i++) begin
                if (k_valid_o[i] && k_ready_i[i]) begin
                    if (qk[i].size() == 0) chk($sformatf("cut_unexpected_out%0d", i), 32'(k_data_o[i*DW +: DW]), 32'hFFFF_FFFF);
                    else chk($sformatf("cut_data_out%0d", i), 32'(k_data_o[i*DW +: DW]), 32'(qk[i].pop_front()));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_comb_valid", 32'(c_valid_o), 32'h0);
        chk("rst_comb_ready", 32'(c_ready_o), 32'h0);
        chk("rst_cut_valid", 32'(k_valid_o), 32'h0);
        step();
        step();
        rst_ni = 1'b1;
        k_sel_i = 2'b11;
        @(negedge clk_i);
        chk("cut_first_ready", 32'(k_ready_o), 32'h1);
        chk("comb_idle_ready", 32'(c_ready_o), 32'h0);
        k_sel_i = 2'b00;
        step();

        // Comb broadcast with all ready
        c_valid_i = 1'b1; c_sel_i = 3'b111; c_ready_i = 3'b111; c_data_i = 8'hA5;
        for (int i = 0; i < int'(NC); i++) qc[i].push_back(8'hA5);
        @(negedge clk_i);
        chk("bcast_valid", 32'(c_valid_o), 32'h7);
        chk("bcast_ready", 32'(c_ready_o), 32'h1);
        chk("bcast_data", 32'(c_data_o), 32'hA5A5A5);
        step();

        // Comb staggered readies
        c_sel_i = 3'b101; c_data_i = 8'h3C; c_ready_i = 3'b001;
        qc[0].push_back(8'h3C); qc[2].push_back(8'h3C);
        @(negedge clk_i);
        chk("stag0_valid", 32'(c_valid_o), 32'h5);
        chk("stag0_ready", 32'(c_ready_o), 32'h0);
        step();
        c_ready_i = 3'b000;
        @(negedge clk_i);
        chk("stag1_valid", 32'(c_valid_o), 32'h4);
        chk("stag1_ready", 32'(c_ready_o), 32'h0);
        step();
        c_ready_i = 3'b100;
        @(negedge clk_i);
        chk("stag2_valid", 32'(c_valid_o), 32'h4);
        chk("stag2_ready", 32'(c_ready_o), 32'h1);
        step();

        // Comb empty mask
        c_sel_i = 3'b000; c_data_i = 8'h11; c_ready_i = 3'b000;
        @(negedge clk_i);
        chk("comb_empty_ready", 32'(c_ready_o), 32'h1);
        chk("comb_empty_valid", 32'(c_valid_o), 32'h0);
        step();

        // Comb reset mid-beat: output 0 done, output 1 pending
        c_sel_i = 3'b011; c_data_i = 8'h77; c_ready_i = 3'b001;
        qc[0].push_back(8'h77);
        @(negedge clk_i);
        chk("mid_valid", 32'(c_valid_o), 32'h3);
        chk("mid_ready", 32'(c_ready_o), 32'h0);
        step();
        c_ready_i = 3'b000;
        @(negedge clk_i);
        chk("mid_pending_valid", 32'(c_valid_o), 32'h2);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(c_valid_o), 32'h0);
        chk("mid_rst_ready", 32'(c_ready_o), 32'h0);
        step();
        rst_ni = 1'b1;
        c_ready_i = 3'b011;
        qc[0].push_back(8'h77); qc[1].push_back(8'h77);
        @(negedge clk_i);
        chk("redeliver_valid", 32'(c_valid_o), 32'h3);
        chk("redeliver_ready", 32'(c_ready_o), 32'h1);
        step();
        c_valid_i = 1'b0; c_sel_i = '0; c_ready_i = '0;

        // Cut back-to-back
        k_valid_i = 1'b1; k_sel_i = 2'b11; k_ready_i = 2'b11;
        for (int b = 1; b <= 3; b++) begin
            k_data_i = 8'(b);
            qk[0].push_back(8'(b)); qk[1].push_back(8'(b));
            @(negedge clk_i);
            chk($sformatf("b2b_ready_%0d", b), 32'(k_ready_o), 32'h1);
            chk($sformatf("b2b_valid_%0d", b), 32'(k_valid_o), (b == 1) ? 32'h0 : 32'h3);
            step();
        end
        k_valid_i = 1'b0;
        @(negedge clk_i);
        chk("b2b_last_valid", 32'(k_valid_o), 32'h3);
        step();
        @(negedge clk_i);
        chk("b2b_drained", 32'(k_valid_o), 32'h0);

        // Cut empty mask
        step();
        k_valid_i = 1'b1; k_sel_i = 2'b00; k_ready_i = 2'b00; k_data_i = 8'h99;
        @(negedge clk_i);
        chk("cut_empty_ready", 32'(k_ready_o), 32'h1);
        step();
        k_valid_i = 1'b0;
        @(negedge clk_i);
        chk("cut_empty_valid", 32'(k_valid_o), 32'h0);
        step();

        // Cut backpressure: fill output 1, then route around it, then stall on it
        k_valid_i = 1'b1; k_sel_i = 2'b10; k_data_i = 8'h44; k_ready_i = 2'b00;
        qk[1].push_back(8'h44);
        @(negedge clk_i);
        chk("bp_fill_ready", 32'(k_ready_o), 32'h1);
        step();
        k_sel_i = 2'b01; k_data_i = 8'h55;
        qk[0].push_back(8'h55);
        @(negedge clk_i);
        chk("bp_side_ready", 32'(k_ready_o), 32'h1);
        step();
        k_sel_i = 2'b11; k_data_i = 8'h66; k_ready_i = 2'b01;
        @(negedge clk_i);
        chk("bp_stall_ready", 32'(k_ready_o), 32'h0);
        chk("bp_stall_valid", 32'(k_valid_o), 32'h3);
        step();
        k_ready_i = 2'b11;
        qk[0].push_back(8'h66); qk[1].push_back(8'h66);
        @(negedge clk_i);
        chk("bp_release_ready", 32'(k_ready_o), 32'h1);
        chk("bp_release_valid", 32'(k_valid_o), 32'h2);
        step();
        k_valid_i = 1'b0;
        @(negedge clk_i);
        chk("bp_final_valid", 32'(k_valid_o), 32'h3);
        step();
        @(negedge clk_i);
        chk("bp_drained", 32'(k_valid_o), 32'h0);
        k_sel_i = '0; k_ready_i = '0;
        step();

        for (int i = 0; i < int'(NC); i++) chk($sformatf("comb_q%0d_empty", i), 32'(qc[i].size()), 32'h0);
        for (int i = 0; i < int'(NK); i++) chk($sformatf("cut_q%0d_empty", i), 32'(qk[i].size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
